// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
// Checks and decodes the 4-bit one-hot ring counter output. Each valid cycle it
// confirms the vector is one-hot and has rotated one place left. After
// LOCK_CYCLES correct rotations it locks. While locked it reports the phase,
// counts completed revolutions and flags rotation faults.
//
// Parameters
//   LOCK_CYCLES : consecutive correct rotations needed to lock (1..15)
//   REV_W       : revolution counter width (wraps)
//   ERR_W       : error counter width (saturates)
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   ring_in    in   one-hot vector from the ring counter
//   in_valid   in   ring_in is sampled only when high
//   clr_fault  in   clears the sticky fault flag
//   locked     out  monitor is locked to a correct rotation
//   phase      out  index of the last accepted sample, 0 when not locked
//   rev_pulse  out  one-cycle pulse per completed revolution while locked
//   rev_cnt    out  revolution count
//   err_pulse  out  one-cycle pulse per rotation fault while locked
//   err_cnt    out  fault count
//   fault      out  sticky fault flag
module ring_phase_monitor #(
    parameter int LOCK_CYCLES = 4,
    parameter int REV_W       = 8,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ring_in,
    input  logic             in_valid,
    input  logic             clr_fault,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             rev_pulse,
    output logic [REV_W-1:0] rev_cnt,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fault
);

    localparam logic [0:0]       ST_ACQUIRE = 1'b0;
    localparam logic [0:0]       ST_LOCKED  = 1'b1;
    localparam logic [3:0]       LOCK_TGT   = 4'(LOCK_CYCLES);
    localparam logic [3:0]       PHASE0     = 4'b0001;
    localparam logic [REV_W-1:0] REV_ONE    = REV_W'(1'b1);
    localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1'b1);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};

    // Expected successor of a ring value: one place left, bit 3 wraps to bit 0.
    function automatic logic [3:0] rot_left(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    // A sample is legal only with exactly one bit set.
    function automatic logic is_onehot(input logic [3:0] v);
        logic r;
        case (v)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Bit position of a one-hot value; only meaningful for legal values.
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] r;
        case (v)
            4'b0010: r = 2'd1;
            4'b0100: r = 2'd2;
            4'b1000: r = 2'd3;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    logic [0:0]       state_r,     state_s;
    logic [3:0]       prev_r,      prev_s;
    logic             have_prev_r, have_prev_s;
    logic [3:0]       lock_cnt_r,  lock_cnt_s;
    logic             locked_r,    locked_s;
    logic [1:0]       phase_r,     phase_s;
    logic             rev_pulse_r, rev_pulse_s;
    logic [REV_W-1:0] rev_cnt_r,   rev_cnt_s;
    logic             err_pulse_r, err_pulse_s;
    logic [ERR_W-1:0] err_cnt_r,   err_cnt_s;
    logic             fault_r,     fault_s;
    logic             legal_s;
    logic             match_s;
    logic             err_hit_s;
    logic [3:0]       lock_inc_s;

    // Next-state logic for the lock FSM, sample history, counters and flags.
    always_comb begin
        state_s     = state_r;
        prev_s      = prev_r;
        have_prev_s = have_prev_r;
        lock_cnt_s  = lock_cnt_r;
        rev_pulse_s = 1'b0;
        rev_cnt_s   = rev_cnt_r;
        err_pulse_s = 1'b0;
        err_cnt_s   = err_cnt_r;
        err_hit_s   = 1'b0;
        legal_s     = is_onehot(ring_in);
        // A match needs a real predecessor; with no history nothing can match.
        match_s     = have_prev_r && (ring_in == rot_left(prev_r));
        lock_inc_s  = lock_cnt_r + 4'd1;

        if (in_valid) begin
            case (state_r)
                ST_ACQUIRE: begin
                    if (!legal_s) begin
                        have_prev_s = 1'b0;
                        lock_cnt_s  = 4'd0;
                    end else if (match_s) begin
                        prev_s = ring_in;
                        if (lock_inc_s == LOCK_TGT) begin
                            // Locking never counts a revolution, even on 0001.
                            state_s    = ST_LOCKED;
                            lock_cnt_s = 4'd0;
                        end else begin
                            lock_cnt_s = lock_inc_s;
                        end
                    end else begin
                        prev_s      = ring_in;
                        have_prev_s = 1'b1;
                        lock_cnt_s  = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (match_s) begin
                        prev_s = ring_in;
                        if (ring_in == PHASE0) begin
                            rev_pulse_s = 1'b1;
                            rev_cnt_s   = rev_cnt_r + REV_ONE;
                        end else begin
                            rev_pulse_s = 1'b0;
                        end
                    end else begin
                        err_hit_s  = 1'b1;
                        state_s    = ST_ACQUIRE;
                        lock_cnt_s = 4'd0;
                        if (legal_s) begin
                            prev_s      = ring_in;
                            have_prev_s = 1'b1;
                        end else begin
                            have_prev_s = 1'b0;
                        end
                    end
                end
                default: begin
                    state_s     = ST_ACQUIRE;
                    have_prev_s = 1'b0;
                    lock_cnt_s  = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        if (err_hit_s) begin
            err_pulse_s = 1'b1;
            err_cnt_s   = (err_cnt_r == ERR_MAX) ? err_cnt_r : (err_cnt_r + ERR_ONE);
        end else begin
            err_pulse_s = 1'b0;
        end

        // A new fault outranks a simultaneous clear request.
        if (err_hit_s) begin
            fault_s = 1'b1;
        end else if (clr_fault) begin
            fault_s = 1'b0;
        end else begin
            fault_s = fault_r;
        end

        locked_s = (state_s == ST_LOCKED);
        phase_s  = locked_s ? onehot_idx(prev_s) : 2'd0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_ACQUIRE;
            prev_r      <= 4'd0;
            have_prev_r <= 1'b0;
            lock_cnt_r  <= 4'd0;
            locked_r    <= 1'b0;
            phase_r     <= 2'd0;
            rev_pulse_r <= 1'b0;
            rev_cnt_r   <= {REV_W{1'b0}};
            err_pulse_r <= 1'b0;
            err_cnt_r   <= {ERR_W{1'b0}};
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            prev_r      <= prev_s;
            have_prev_r <= have_prev_s;
            lock_cnt_r  <= lock_cnt_s;
            locked_r    <= locked_s;
            phase_r     <= phase_s;
            rev_pulse_r <= rev_pulse_s;
            rev_cnt_r   <= rev_cnt_s;
            err_pulse_r <= err_pulse_s;
            err_cnt_r   <= err_cnt_s;
            fault_r     <= fault_s;
        end
    end

    assign locked    = locked_r;
    assign phase     = phase_r;
    assign rev_pulse = rev_pulse_r;
    assign rev_cnt   = rev_cnt_r;
    assign err_pulse = err_pulse_r;
    assign err_cnt   = err_cnt_r;
    assign fault     = fault_r;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Self-checking bench for ring_phase_monitor. A behavioural model predicts every
// output when a sample is driven; predictions wait in a queue and are compared
// one cycle later. Directed constant checks mark the key scenario points.
// A second instance with REV_W=2 shares the inputs to exercise counter wrap.
module tb_ring_phase_monitor;

    logic       clk;
    logic       reset;
    logic [3:0] ring_in;
    logic       in_valid;
    logic       clr_fault;

    logic       locked,    locked2;
    logic [1:0] phase,     phase2;
    logic       rev_pulse, rev_pulse2;
    logic [7:0] rev_cnt;
    logic [1:0] rev_cnt2;
    logic       err_pulse, err_pulse2;
    logic [3:0] err_cnt,   err_cnt2;
    logic       fault,     fault2;

    int tests = 0;
    int fails = 0;

    ring_phase_monitor #(.LOCK_CYCLES(4), .REV_W(8), .ERR_W(4)) u_dut (
        .clk(clk), .reset(reset), .ring_in(ring_in), .in_valid(in_valid),
        .clr_fault(clr_fault), .locked(locked), .phase(phase),
        .rev_pulse(rev_pulse), .rev_cnt(rev_cnt), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .fault(fault)
    );

    ring_phase_monitor #(.LOCK_CYCLES(4), .REV_W(2), .ERR_W(4)) u_dut2 (
        .clk(clk), .reset(reset), .ring_in(ring_in), .in_valid(in_valid),
        .clr_fault(clr_fault), .locked(locked2), .phase(phase2),
        .rev_pulse(rev_pulse2), .rev_cnt(rev_cnt2), .err_pulse(err_pulse2),
        .err_cnt(err_cnt2), .fault(fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       locked;
        logic [1:0] phase;
        logic       rev_pulse;
        logic [7:0] rev_cnt;
        logic [1:0] rev_cnt2;
        logic       err_pulse;
        logic [3:0] err_cnt;
        logic       fault;
    } exp_t;

    exp_t sb_q[$];

    // Model state, tracked as plain integers.
    int m_locked;
    int m_prev;     // phase index of last accepted sample, -1 = none
    int m_lcnt;
    int m_rev;
    int m_err;
    int m_fault;
    int m_rp;
    int m_ep;

    function automatic int sample_idx(input logic [3:0] v);
        int ones = 0;
        int pos  = -1;
        for (int i = 0; i < 4; i++) begin
            if (v[i] === 1'b1) begin
                ones++;
                pos = i;
            end
        end
        return (ones == 1) ? pos : -1;
    endfunction

    task automatic model(input logic [3:0] r, input logic v, input logic c, input logic rs);
        int idx;
        m_rp = 0;
        m_ep = 0;
        if (rs) begin
            m_locked = 0; m_prev = -1; m_lcnt = 0;
            m_rev = 0; m_err = 0; m_fault = 0;
        end else begin
            if (v) begin
                idx = sample_idx(r);
                if (m_locked == 0) begin
                    if (idx < 0) begin
                        m_prev = -1;
                        m_lcnt = 0;
                    end else if (m_prev >= 0 && idx == (m_prev + 1) % 4) begin
                        m_prev = idx;
                        m_lcnt++;
                        if (m_lcnt == 4) begin
                            m_locked = 1;
                            m_lcnt = 0;
                        end
                    end else begin
                        m_prev = idx;
                        m_lcnt = 0;
                    end
                end else begin
                    if (idx >= 0 && idx == (m_prev + 1) % 4) begin
                        m_prev = idx;
                        if (idx == 0) begin
                            m_rp = 1;
                            m_rev++;
                        end
                    end else begin
                        m_ep = 1;
                        if (m_err < 15) m_err++;
                        m_locked = 0;
                        m_lcnt = 0;
                        m_prev = idx;
                    end
                end
            end
            if (m_ep == 1) m_fault = 1;
            else if (c) m_fault = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict, then compare the prediction against the outputs.
    task automatic step(input logic [3:0] r, input logic v, input logic c, input logic rs);
        exp_t e;
        @(negedge clk);
        ring_in   = r;
        in_valid  = v;
        clr_fault = c;
        reset     = rs;
        model(r, v, c, rs);
        e.locked    = 1'(m_locked);
        e.phase     = (m_locked != 0) ? 2'(m_prev) : 2'd0;
        e.rev_pulse = 1'(m_rp);
        e.rev_cnt   = 8'(m_rev % 256);
        e.rev_cnt2  = 2'(m_rev % 4);
        e.err_pulse = 1'(m_ep);
        e.err_cnt   = 4'(m_err);
        e.fault     = 1'(m_fault);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb_locked",     locked,     e.locked);
        chk("sb_phase",      phase,      e.phase);
        chk("sb_rev_pulse",  rev_pulse,  e.rev_pulse);
        chk("sb_rev_cnt",    rev_cnt,    e.rev_cnt);
        chk("sb_err_pulse",  err_pulse,  e.err_pulse);
        chk("sb_err_cnt",    err_cnt,    e.err_cnt);
        chk("sb_fault",      fault,      e.fault);
        chk("sb2_rev_cnt",   rev_cnt2,   e.rev_cnt2);
        chk("sb2_rev_pulse", rev_pulse2, e.rev_pulse);
        chk("sb2_locked",    locked2,    e.locked);
        chk("sb2_phase",     phase2,     e.phase);
        chk("sb2_err_pulse", err_pulse2, e.err_pulse);
        chk("sb2_err_cnt",   err_cnt2,   e.err_cnt);
        chk("sb2_fault",     fault2,     e.fault);
    endtask

    // From no history: five correct samples ending on 0001 give lock.
    task automatic relock();
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
    endtask

    // From phase 0: n full revolutions ending back on 0001.
    task automatic revs(input int n);
        for (int i = 0; i < n; i++) begin
            step(4'b0010, 1'b1, 1'b0, 1'b0);
            step(4'b0100, 1'b1, 1'b0, 1'b0);
            step(4'b1000, 1'b1, 1'b0, 1'b0);
            step(4'b0001, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ring_in = 4'b0000; in_valid = 1'b0; clr_fault = 1'b0; reset = 1'b1;

        // Reset state
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        step(4'b0001, 1'b1, 1'b1, 1'b1);
        chk("rst_locked", locked, 1'b0);
        chk("rst_err_cnt", err_cnt, 4'd0);
        chk("rst_rev_cnt", rev_cnt, 8'd0);

        // Lock from reset
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        chk("lock4_not_yet", locked, 1'b0);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        chk("lock5_locked", locked, 1'b1);
        chk("lock5_phase", phase, 2'd0);
        chk("lock5_no_rev", rev_pulse, 1'b0);

        // Revolution count and REV_W=2 wrap
        revs(3);
        chk("rev3_cnt", rev_cnt, 8'd3);
        chk("rev3_pulse", rev_pulse, 1'b1);
        revs(1);
        chk("rev4_cnt", rev_cnt, 8'd4);
        chk("rev4_wrap2", rev_cnt2, 2'd0);
        chk("rev4_pulse2", rev_pulse2, 1'b1);
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        chk("phase1", phase, 2'd1);

        // Fault: skip from phase 1 to 1000
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        chk("skip_err_pulse", err_pulse, 1'b1);
        chk("skip_err_cnt", err_cnt, 4'd1);
        chk("skip_fault", fault, 1'b1);
        chk("skip_unlocked", locked, 1'b0);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        chk("relock3_not_yet", locked, 1'b0);
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        chk("relock4_locked", locked, 1'b1);
        chk("relock4_phase", phase, 2'd3);
        chk("relock4_fault", fault, 1'b1);

        // Illegal vectors
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        chk("zero_err_cnt", err_cnt, 4'd2);
        step(4'b0110, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("acq_illegal_err_cnt", err_cnt, 4'd2);
        chk("acq_illegal_unlocked", locked, 1'b0);
        for (int i = 0; i < 15; i++) begin
            relock();
            step(4'b0000, 1'b1, 1'b0, 1'b0);
        end
        chk("sat_err_cnt", err_cnt, 4'd15);
        chk("sat_err_pulse", err_pulse, 1'b1);
        chk("sat_fault", fault, 1'b1);

        // Valid gating
        relock();
        for (int i = 0; i < 5; i++) begin
            step(4'b0000, 1'b0, 1'b0, 1'b0);
            chk("gate_locked", locked, 1'b1);
            chk("gate_no_err", err_pulse, 1'b0);
            chk("gate_no_rev", rev_pulse, 1'b0);
        end
        // Clear together with a new fault, then clear alone
        step(4'b0100, 1'b1, 1'b1, 1'b0);
        chk("clr_vs_err_fault", fault, 1'b1);
        chk("clr_vs_err_pulse", err_pulse, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        chk("clr_alone_fault", fault, 1'b0);
        chk("clr_keeps_err_cnt", err_cnt, 4'd15);

        // Reset mid-operation
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        relock();
        revs(5);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        relock();
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        relock();
        chk("pre_rst_rev", rev_cnt, 8'd5);
        chk("pre_rst_err", err_cnt, 4'd2);
        chk("pre_rst_locked", locked, 1'b1);
        step(4'b0010, 1'b1, 1'b1, 1'b1);
        chk("mid_rst_locked", locked, 1'b0);
        chk("mid_rst_rev", rev_cnt, 8'd0);
        chk("mid_rst_err", err_cnt, 4'd0);
        chk("mid_rst_fault", fault, 1'b0);
        chk("mid_rst_err_pulse", err_pulse, 1'b0);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        chk("post_rst_not_yet", locked, 1'b0);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        chk("post_rst_locked", locked, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ring_phase_monitor.md
# ring_phase_monitor

Downstream checker and decoder for the 4-bit one-hot ring counter output. It samples the ring vector each valid cycle and verifies that the vector is legal one-hot and rotates correctly. It locks onto the sequence, reports the current phase index, counts completed revolutions and records rotation faults. It sits directly on the ring counter's `out` bus, in the same clock domain.

## Interface
- `LOCK_CYCLES`, 4: consecutive correct rotations required to lock; legal range 1..15.
- `REV_W`, 8: width of the revolution counter.
- `ERR_W`, 4: width of the error counter.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `ring_in`  in  4  one-hot vector from the ring counter.
- `in_valid`  in  1  `ring_in` is sampled only when high.
- `clr_fault`  in  1  clears sticky `fault`.
- `locked`  out  1  monitor is locked to a correct rotation.
- `phase`  out  2  index of the last accepted sample: 0001→0, 0010→1, 0100→2, 1000→3. Forced 0 when not locked.
- `rev_pulse`  out  1  one-cycle pulse on each completed revolution while locked.
- `rev_cnt`  out  REV_W  revolution count; wraps.
- `err_pulse`  out  1  one-cycle pulse on a rotation fault while locked.
- `err_cnt`  out  ERR_W  fault count; saturates at all ones.
- `fault`  out  1  sticky fault flag.

## Operation
- Required rotation is left: 0001→0010→0100→1000→0001. `rot(x) = {x[2:0], x[3]}`.
- A sample is legal when `ring_in` has exactly one bit set.
- Internal state:
  - `prev`: 4-bit last accepted sample.
  - `have_prev`: flag that `prev` holds a legal sample.
  - `lock_cnt`: 4 bits.
  - FSM with two states, ACQUIRE and LOCKED.
- ACQUIRE, per valid sample:
  - Illegal sample: `have_prev`=0, `lock_cnt`=0. No error is counted.
  - Legal sample, and either `have_prev`=0 or sample ≠ `rot(prev)`: `prev`=sample, `have_prev`=1, `lock_cnt`=0.
  - Legal sample equal to `rot(prev)`: `prev`=sample, `lock_cnt`+1. When the new count reaches `LOCK_CYCLES`, go to LOCKED and set `lock_cnt`=0.
- LOCKED, per valid sample:
  - Sample equal to `rot(prev)`: `prev`=sample. If the sample is 0001, pulse `rev_pulse` and increment `rev_cnt` (mod 2^REV_W).
  - Any other sample, including illegal or held values: pulse `err_pulse`, increment `err_cnt` with saturation, set `fault`, go to ACQUIRE with `lock_cnt`=0. If the sample is legal, `prev`=sample and `have_prev`=1; otherwise `have_prev`=0.
- When `in_valid`=0: no state, `prev` or counter change. `rev_pulse` and `err_pulse` are 0.
- The locking transition itself never produces `rev_pulse`, even when the sample is 0001.
- `clr_fault` clears `fault` next cycle. If an error sets `fault` in the same cycle, the set wins and `fault` stays 1.
- `clr_fault` does not clear `err_cnt`; only `reset` clears it.

## Timing
- All outputs are registered. A sample at edge N is reflected on outputs after edge N; latency is one cycle.
- `phase` updates in the same cycle as `prev`.
- Pulses are high for exactly one cycle per qualifying sample. Back-to-back qualifying samples give back-to-back pulses.
- `reset` high at a rising edge sets:
  - FSM = ACQUIRE, `have_prev`=0, `lock_cnt`=0.
  - `locked`=0, `phase`=0, `rev_pulse`=0, `rev_cnt`=0, `err_pulse`=0, `err_cnt`=0, `fault`=0.
- `reset` overrides `in_valid` and `clr_fault`. Asserting `reset` mid-revolution or while LOCKED drops lock the following cycle and counts no error.
- `rev_cnt` wraps from 2^REV_W−1 to 0 with `rev_pulse` still asserted.
- `err_cnt` at its maximum stays at maximum; `err_pulse` and `fault` still assert.

## Test plan
- **Lock from reset.** Defaults; release `reset`, then drive 0001, 0010, 0100, 1000, 0001 with `in_valid`=1 → `locked` rises after the 5th sample. `phase`=0. No `rev_pulse`. Next 0010 gives `phase`=1.
- **Revolution count.** Locked; run 3 full revolutions → exactly 3 `rev_pulse`, one on each 0001, and `rev_cnt`=3. With `REV_W`=2, 4 revolutions → `rev_cnt` wraps to 0.
- **Fault handling.** Locked at `phase`=1; drive 1000 (skip) → `err_pulse`=1, `err_cnt`=1, `fault`=1, `locked`=0. Then 0001, 0010, 0100, 1000 → relocks after the 4th correct rotation. `fault` remains 1.
- **Illegal vectors.** Locked; drive 0000 → error counted. Then in ACQUIRE drive 0110, 1111 → `err_cnt` unchanged, no lock. Force 16 faults with `ERR_W`=4 → `err_cnt` saturates at 15.
- **Valid gating and clear.** Locked; hold `in_valid`=0 for 5 cycles while `ring_in`=0000 → no change, no pulses. Assert `clr_fault` in the same cycle as a new fault → `fault` stays 1. `clr_fault` alone → `fault`=0 next cycle.
- **Reset mid-operation.** Locked with `rev_cnt`=5, `err_cnt`=2; pulse `reset` for one cycle → all outputs 0. Relock requires 4 new correct rotations.
